// File: rtl/bus_mem_responder.sv
// Target of the CPU byte bus: on-chip byte RAM plus a three-register I/O page.
// After reset it loads a program image from a byte stream, then releases the CPU.
module bus_mem_responder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [15:0] IO_BASE   = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  di,
    output logic [7:0]  dout,
    input  logic        we,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_rst,
    output logic [7:0]  out_port,
    output logic        load_ovf
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic [7:0]    out_port_q, out_port_d;
    logic          load_ovf_q, load_ovf_d;
    logic [7:0]    cycle_cnt_q, cycle_cnt_d;
    logic [7:0]    io_rdata_q, io_rdata_d;
    logic          ram_sel_q, ram_sel_d;
    logic [7:0]    ram_rdata_q;

    logic [7:0]    mem [MEM_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic          in_ram;
    logic          is_out;
    logic          is_stat;
    logic          is_cnt;
    logic          load_xfer;

    assign in_ram    = (32'(addr) < MEM_DEPTH);
    assign is_out    = (addr == IO_BASE);
    assign is_stat   = (addr == IO_BASE + 16'd1);
    assign is_cnt    = (addr == IO_BASE + 16'd2);
    assign load_xfer = load_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        load_ovf_d  = load_ovf_q;
        out_port_d  = out_port_q;
        cycle_cnt_d = cycle_cnt_q;
        cpu_rst_d   = (state_q == ST_LOAD);
        io_rdata_d  = 8'h00;
        ram_sel_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr[AW-1:0];
        mem_wdata   = di;

        if (state_q == ST_LOAD) begin
            // The CPU bus is ignored here; dout stays 0 because io_rdata_d/ram_sel_d keep defaults.
            if (load_xfer) begin
                mem_we    = 1'b1;
                mem_waddr = load_ptr_q;
                mem_wdata = load_data;
                if (load_ptr_q == AW'(MEM_DEPTH - 1)) begin
                    // Last slot: stop here rather than wrapping onto address 0.
                    load_ovf_d = !load_last;
                    state_d    = ST_RUN;
                end else begin
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
        end else begin
            cycle_cnt_d = cycle_cnt_q + 8'd1;
            ram_sel_d   = in_ram;
            if (is_out) begin
                io_rdata_d = out_port_q;
            end else if (is_stat) begin
                io_rdata_d = {5'b0, load_ovf_q, (state_q == ST_RUN), 1'b1};
            end else if (is_cnt) begin
                io_rdata_d = cycle_cnt_q;
            end
            if (we) begin
                if (in_ram) begin
                    mem_we = 1'b1;
                end else if (is_out) begin
                    out_port_d = di;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_ptr_q  <= '0;
            cpu_rst_q   <= 1'b1;
            out_port_q  <= 8'h00;
            load_ovf_q  <= 1'b0;
            cycle_cnt_q <= 8'h00;
            io_rdata_q  <= 8'h00;
            ram_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            cpu_rst_q   <= cpu_rst_d;
            out_port_q  <= out_port_d;
            load_ovf_q  <= load_ovf_d;
            cycle_cnt_q <= cycle_cnt_d;
            io_rdata_q  <= io_rdata_d;
            ram_sel_q   <= ram_sel_d;
        end
    end

    // RAM keeps its contents across rst; the registered read gives read-before-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        ram_rdata_q <= mem[addr[AW-1:0]];
    end

    assign dout       = ram_sel_q ? ram_rdata_q : io_rdata_q;
    assign load_ready = (state_q == ST_LOAD);
    assign cpu_rst    = cpu_rst_q;
    assign out_port   = out_port_q;
    assign load_ovf   = load_ovf_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: program load, CPU RAM/I/O access,
// load overflow and reset during load.
module tb_bus_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        we;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_rst;
    logic [7:0]  out_port;
    logic        load_ovf;

    int n_vec = 0;
    int n_bad = 0;

    bus_mem_responder #(
        .MEM_DEPTH (1024),
        .IO_BASE   (16'hFF00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .di         (di),
        .dout       (dout),
        .we         (we),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_rst    (cpu_rst),
        .out_port   (out_port),
        .load_ovf   (load_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%02h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        di   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic cpu_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        we   = 1'b0;
        tick();
        chk(tag, dout, exp);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        addr       = 16'h0000;
        di         = 8'h00;
        we         = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        tick();
        tick();
        chk("rst_cpu_rst", 8'(cpu_rst), 8'h01);
        chk("rst_load_ready", 8'(load_ready), 8'h01);
        chk("rst_dout", dout, 8'h00);
        chk("rst_out_port", out_port, 8'h00);
        chk("rst_load_ovf", 8'(load_ovf), 8'h00);
        rst = 1'b0;

        // Load four bytes with an idle gap; the gap must not advance the pointer.
        load_byte(8'h10, 1'b0);
        load_byte(8'h20, 1'b0);
        tick();
        load_byte(8'h30, 1'b0);
        load_byte(8'h40, 1'b1);
        chk("run_load_ready", 8'(load_ready), 8'h00);
        chk("run_cpu_rst_still_high", 8'(cpu_rst), 8'h01);
        cpu_rd("cycle_cnt_first", 16'hFF02, 8'h00);
        chk("cpu_rst_fell", 8'(cpu_rst), 8'h00);
        cpu_rd("cycle_cnt_second", 16'hFF02, 8'h01);
        cpu_rd("ram0", 16'h0000, 8'h10);
        cpu_rd("ram1", 16'h0001, 8'h20);
        cpu_rd("ram2", 16'h0002, 8'h30);
        cpu_rd("ram3", 16'h0003, 8'h40);

        cpu_wr(16'h0005, 8'hA5);
        cpu_rd("wr_rd_5", 16'h0005, 8'hA5);

        // Same-edge write and read returns the old contents.
        cpu_wr(16'h0005, 8'h77);
        chk("rbw_old", dout, 8'hA5);
        cpu_rd("rbw_new", 16'h0005, 8'h77);

        cpu_wr(16'hFF00, 8'h3C);
        chk("out_port_wr", out_port, 8'h3C);
        cpu_rd("out_port_rd", 16'hFF00, 8'h3C);
        cpu_wr(16'hFF01, 8'hFF);
        cpu_rd("status_ro", 16'hFF01, 8'h03);
        cpu_rd("unmapped_8000", 16'h8000, 8'h00);
        cpu_wr(16'h03FF, 8'hE1);
        cpu_rd("ram_top", 16'h03FF, 8'hE1);
        cpu_wr(16'h0400, 8'hBB);
        cpu_rd("unmapped_0400", 16'h0400, 8'h00);
        cpu_rd("no_alias_0", 16'h0000, 8'h10);
        chk("out_port_kept", out_port, 8'h3C);

        // Reset part-way through a load.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_out_port", out_port, 8'h00);
        load_byte(8'hB1, 1'b0);
        load_byte(8'hB2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midload_cpu_rst", 8'(cpu_rst), 8'h01);
        chk("midload_load_ready", 8'(load_ready), 8'h01);
        chk("midload_dout", dout, 8'h00);
        load_byte(8'h99, 1'b1);
        cpu_rd("reload_ram0", 16'h0000, 8'h99);
        cpu_rd("reload_ram1", 16'h0001, 8'hB2);
        cpu_rd("reload_ram2", 16'h0002, 8'h30);
        cpu_rd("reload_ram3ff", 16'h03FF, 8'hE1);

        // Overflow: a full RAM's worth of bytes with no load_last.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            load_byte(8'(i * 7 + 3), 1'b0);
            if (i == 1022) begin
                chk("ovf_pre_ready", 8'(load_ready), 8'h01);
                chk("ovf_pre_flag", 8'(load_ovf), 8'h00);
            end
        end
        chk("ovf_flag", 8'(load_ovf), 8'h01);
        chk("ovf_load_ready", 8'(load_ready), 8'h00);
        load_valid = 1'b1;
        load_data  = 8'hEE;
        cpu_rd("ovf_status", 16'hFF01, 8'h07);
        load_valid = 1'b0;
        cpu_rd("ovf_ram0", 16'h0000, 8'h03);
        cpu_rd("ovf_ram1", 16'h0001, 8'h0A);
        cpu_rd("ovf_ram3fe", 16'h03FE, 8'hF5);
        cpu_rd("ovf_ram3ff", 16'h03FF, 8'hFC);

        rst = 1'b1;
        tick();
        chk("final_ovf_clr", 8'(load_ovf), 8'h00);
        chk("final_cpu_rst", 8'(cpu_rst), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
